// File: rtl/spi_scheduler_pkg.sv
// Shared SPI package: frame constants for the serial engine, scheduler state
// encoding and the post-frame guard length.
package spi_scheduler_pkg;

  localparam int CFG_FRAME_BITS = 40;
  localparam int DAC_FRAME_BITS = 24;

  // Guard covers the engine's LOAD/read-strobe latency plus its output write.
  localparam int GUARD_CYC = 2;
  localparam int GUARD_W   = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CFG_WAIT = 2'd1,
    ST_DAC_WAIT = 2'd2,
    ST_GUARD    = 2'd3
  } sched_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Sample-period tick generator: free-running 0..period-1 counter while run is
// high, with run rising-edge detection. Periods 0 and 1 behave as 2.
module spi_tick_gen #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_run,
  input  logic [PERIOD_W-1:0] i_period,
  output logic                o_tick,
  output logic                o_run_rise
);

  logic [PERIOD_W-1:0] r_cnt;
  logic                r_run_d;
  logic [PERIOD_W-1:0] w_last;

  assign w_last = (i_period < PERIOD_W'(2)) ? PERIOD_W'(1) : i_period - 1'b1;

  // >= keeps the counter from running away if period shrinks mid-count.
  assign o_tick     = i_run && (r_cnt >= w_last);
  assign o_run_rise = i_run && !r_run_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_run_d <= 1'b0;
    end else begin
      r_run_d <= i_run;
      if (!i_run || o_tick) r_cnt <= '0;
      else                  r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_scheduler.sv
// Frame scheduler for the SPI DAC engine: arbitrates DAC samples against
// config frames. Optional watchdog enabled by macro SPI_SCHED_TIMEOUT_EN.
module spi_scheduler
  import spi_scheduler_pkg::*;
#(
  parameter int PERIOD_W    = 16,
  parameter int TIMEOUT_CYC = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  input  logic [PERIOD_W-1:0] wav_len,
  input  logic                cfg_pending,
  input  logic                wav_empty,
  input  logic                spi_done,
  input  logic                clr_flags,
  output logic                trig_config,
  output logic                trig_dac,
  output logic                busy,
  output logic [PERIOD_W-1:0] sample_cnt,
  output logic                run_done,
  output logic                underrun,
  output logic                overrun,
  output logic                timeout
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  sched_state_t        r_state, w_state_next;
  logic [GUARD_W-1:0]  r_guard_cnt;
  logic                r_tick_pend, r_finished;
  logic                r_trig_dac, r_trig_cfg, r_run_done;
  logic                r_underrun, r_overrun, r_timeout;
  logic [PERIOD_W-1:0] r_sample_cnt;
  logic [PERIOD_W-1:0] w_cnt_inc;
  logic                w_tick, w_run_rise, w_tick_eff, w_tick_take;
  logic                w_trig_dac_next, w_trig_cfg_next, w_consume;
  logic                w_dac_done, w_hit_len, w_abort;

  spi_tick_gen #(.PERIOD_W(PERIOD_W)) u_tick_gen (
    .clk        (clk),
    .rst        (rst),
    .i_run      (run),
    .i_period   (period),
    .o_tick     (w_tick),
    .o_run_rise (w_run_rise)
  );

  assign w_tick_eff  = w_tick && !r_finished;
  assign w_tick_take = w_tick_eff && !wav_empty;
  assign w_dac_done  = (r_state == ST_DAC_WAIT) && spi_done;
  assign w_cnt_inc   = r_sample_cnt + 1'b1;
  assign w_hit_len   = w_dac_done && (wav_len != '0) && (w_cnt_inc == wav_len);

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
  logic [WDOG_W-1:0] r_wdog;
  logic              w_waiting;

  assign w_waiting = (r_state == ST_CFG_WAIT) || (r_state == ST_DAC_WAIT);
  assign w_abort   = w_waiting && !spi_done && (r_wdog == WDOG_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_wdog <= '0;
    else if (!w_waiting) r_wdog <= '0;
    else                 r_wdog <= r_wdog + 1'b1;
  end
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_trig_dac_next = 1'b0;
    w_trig_cfg_next = 1'b0;
    w_consume       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_tick_pend) begin
          w_trig_dac_next = 1'b1;
          w_consume       = 1'b1;
          w_state_next    = ST_DAC_WAIT;
        end else if (cfg_pending) begin
          w_trig_cfg_next = 1'b1;
          w_state_next    = ST_CFG_WAIT;
        end
      end
      ST_CFG_WAIT, ST_DAC_WAIT: begin
        if (spi_done || w_abort) w_state_next = ST_GUARD;
      end
      ST_GUARD: begin
        if (r_guard_cnt == GUARD_W'(GUARD_CYC - 1)) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_guard_cnt <= '0;
      r_trig_dac  <= 1'b0;
      r_trig_cfg  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_guard_cnt <= (r_state == ST_GUARD) ? r_guard_cnt + 1'b1 : '0;
      r_trig_dac  <= w_trig_dac_next;
      r_trig_cfg  <= w_trig_cfg_next;
    end
  end

  // A fresh tick re-arms pend even in the cycle IDLE consumes the old one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_pend  <= 1'b0;
      r_finished   <= 1'b0;
      r_sample_cnt <= '0;
      r_run_done   <= 1'b0;
    end else begin
      if (!run || w_hit_len) r_tick_pend <= 1'b0;
      else if (w_tick_take)  r_tick_pend <= 1'b1;
      else if (w_consume)    r_tick_pend <= 1'b0;

      if (!run)           r_finished <= 1'b0;
      else if (w_hit_len) r_finished <= 1'b1;

      if (w_run_rise)      r_sample_cnt <= '0;
      else if (w_dac_done) r_sample_cnt <= w_cnt_inc;

      r_run_done <= w_hit_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_underrun <= (r_underrun && !clr_flags) || (w_tick_eff && wav_empty);
      r_overrun  <= (r_overrun && !clr_flags) || (w_tick_take && r_tick_pend && !w_consume);
      r_timeout  <= (r_timeout && !clr_flags) || w_abort;
    end
  end

  assign trig_dac    = r_trig_dac;
  assign trig_config = r_trig_cfg;
  assign busy        = (r_state != ST_IDLE);
  assign sample_cnt  = r_sample_cnt;
  assign run_done    = r_run_done;
  assign underrun    = r_underrun;
  assign overrun     = r_overrun;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_spi_scheduler.sv
// Bench for spi_scheduler: a behavioural SPI engine answers triggers, and
// expectations come from the period/length/guard rules. Honours SPI_SCHED_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_spi_scheduler;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst, run, cfg_pending, wav_empty, spi_done, clr_flags;
  logic [PW-1:0] period, wav_len, sample_cnt;
  logic          trig_config, trig_dac, busy, run_done, underrun, overrun, timeout;

  always #5 clk = ~clk;

  spi_scheduler #(.PERIOD_W(PW), .TIMEOUT_CYC(128)) dut (
    .clk(clk), .rst(rst), .run(run), .period(period), .wav_len(wav_len),
    .cfg_pending(cfg_pending), .wav_empty(wav_empty), .spi_done(spi_done),
    .clr_flags(clr_flags), .trig_config(trig_config), .trig_dac(trig_dac),
    .busy(busy), .sample_cnt(sample_cnt), .run_done(run_done),
    .underrun(underrun), .overrun(overrun), .timeout(timeout)
  );

  int n_checks = 0, n_pass = 0;

  // Engine model and event log (written only by the engine process).
  int cyc = 0, dac_cnt = 0, cfg_cnt = 0, rd_cnt = 0, viol = 0;
  int dac_t[512], dac_done_t[512];
  int ev_n = 0;
  int ev_kind[1024], ev_t[1024];
  int countdown = 0, cur_dac = -1, last_done = -100;
  bit outstanding = 0;
  // Engine controls (written only by the stimulus process).
  bit resp_en = 1;
  int resp_delay = 4, long_idx = -1, long_delay = 0;

  initial begin
    spi_done = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      spi_done = 1'b0;
      if (rst) begin
        outstanding = 0;
        countdown   = 0;
      end else begin
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            spi_done    = 1'b1;
            outstanding = 0;
            last_done   = cyc;
            if (cur_dac >= 0) dac_done_t[cur_dac] = cyc;
          end
        end
        if (trig_dac || trig_config) begin
          // A trigger may never overlap a frame or land inside the 2-cycle guard.
          if (outstanding || (cyc - last_done < 3) || (trig_dac && trig_config)) viol++;
          outstanding   = 1;
          ev_kind[ev_n] = trig_dac ? 1 : 2;
          ev_t[ev_n]    = cyc;
          ev_n++;
          if (trig_dac) begin
            dac_t[dac_cnt] = cyc;
            cur_dac        = dac_cnt;
            countdown      = (dac_cnt == long_idx) ? long_delay : resp_delay;
            dac_cnt++;
          end else begin
            cfg_cnt++;
            cur_dac   = -1;
            countdown = resp_delay;
          end
          if (!resp_en) countdown = 0;
        end
        if (run_done) rd_cnt++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 1000) begin
      step(1);
      k++;
    end
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  // Plain periodic run: L frames exactly P apart, one run_done, count L.
  task automatic run_case(input string tag, input int p, input int l, input int d);
    int base, rd0, t0, lat;
    period = PW'(p); wav_len = PW'(l); resp_delay = d; wav_empty = 1'b0;
    base = dac_cnt; rd0 = rd_cnt; t0 = cyc;
    run = 1'b1;
    step(l * p + 3 * p);
    check($sformatf("%s_ndac", tag), 32'(dac_cnt - base), 32'(l));
    lat = dac_t[base] - t0;
    check($sformatf("%s_first_lat_%0d", tag, lat), 32'(lat >= p && lat <= p + 2), 1);
    for (int k = 1; k < l; k++)
      check($sformatf("%s_gap%0d", tag, k), 32'(dac_t[base + k] - dac_t[base + k - 1]), 32'(p));
    check($sformatf("%s_run_done", tag), 32'(rd_cnt - rd0), 1);
    check($sformatf("%s_sample_cnt", tag), 32'(sample_cnt), 32'(l));
    run = 1'b0;
    step(4);
    wait_idle(tag);
  endtask

  initial begin
    int base, ev0, idx, didx, gap, cnt, t_trig, k;
    rst = 1'b1; run = 1'b0; cfg_pending = 1'b0; wav_empty = 1'b0; clr_flags = 1'b0;
    period = '0; wav_len = '0;
    step(3);
    check("rst_trig_dac", 32'(trig_dac), 0);
    check("rst_trig_cfg", 32'(trig_config), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sample_cnt", 32'(sample_cnt), 0);
    check("rst_flags", {29'd0, underrun, overrun, timeout}, 0);
    rst = 1'b0;
    step(3);

    run_case("base100", 100, 4, 45);
    for (int r = 0; r < 3; r++) begin
      int p, l, d;
      p = $urandom_range(10, 40);
      l = $urandom_range(1, 5);
      d = $urandom_range(1, p - 6);
      run_case($sformatf("rnd%0d_p%0d_l%0d", r, p, l), p, l, d);
    end
    step(10);
    check("base_no_extra_trig", 32'(viol), 0);

    // Tick pending together with a config request: DAC first, config next.
    period = 16'd30; wav_len = 16'd3; resp_delay = 4; wav_empty = 1'b0;
    base = dac_cnt; ev0 = ev_n;
    cfg_pending = 1'b1; run = 1'b1;
    step(150);
    check("prio_ndac", 32'(dac_cnt - base), 3);
    idx = -1;
    for (int i = ev_n - 1; i >= ev0; i--) if (ev_kind[i] == 1) idx = i;
    check("prio_dac_found", 32'(idx >= 0), 1);
    if (idx < 0) idx = ev0;
    check("prio_next_is_cfg", 32'(ev_kind[idx + 1]), 2);
    gap = ev_t[idx + 1] - dac_done_t[base];
    check($sformatf("prio_cfg_after_guard_%0d", gap), 32'(gap >= 3 && gap <= 4), 1);
    cfg_pending = 1'b0; run = 1'b0;
    step(20);
    wait_idle("prio");
    check("prio_no_overlap", 32'(viol), 0);

    // Withheld spi_done: ticks merge, one catch-up frame follows.
    period = 16'd20; wav_len = 16'd4; resp_delay = 3; wav_empty = 1'b0;
    base = dac_cnt; long_idx = dac_cnt; long_delay = 50;
    run = 1'b1;
    step(200);
    check("ovr_flag", 32'(overrun), 1);
    check("ovr_ndac", 32'(dac_cnt - base), 4);
    check("ovr_sample_cnt", 32'(sample_cnt), 4);
    cnt = 0;
    for (int j = base; j < dac_cnt; j++)
      if (dac_t[j] > dac_done_t[base] && dac_t[j] <= dac_done_t[base] + 6) cnt++;
    check("ovr_one_catchup", 32'(cnt), 1);
    long_idx = -1;
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check("ovr_cleared", 32'(overrun), 0);
    run = 1'b0;
    step(4);
    wait_idle("ovr");

    // Empty waveform source on every tick.
    period = 16'd10; wav_len = 16'd0; wav_empty = 1'b1;
    base = dac_cnt;
    run = 1'b1;
    step(25);
    check("udr_flag", 32'(underrun), 1);
    check("udr_ndac", 32'(dac_cnt - base), 0);
    check("udr_sample_cnt", 32'(sample_cnt), 0);
    run = 1'b0;
    step(2);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check("udr_cleared", 32'(underrun), 0);

    // Reset in the middle of a DAC frame.
    period = 16'd12; wav_len = 16'd0; wav_empty = 1'b1; resp_delay = 3;
    base = dac_cnt;
    run = 1'b1;
    step(14);
    wav_empty = 1'b0;
    k = 0;
    while (dac_cnt < base + 2 && k < 200) begin step(1); k++; end
    resp_en = 1'b0;
    k = 0;
    while (dac_cnt < base + 3 && k < 200) begin step(1); k++; end
    check("rstmid_third_trig", 32'(dac_cnt - base), 3);
    step(5);
    check("rstmid_busy_before", 32'(busy), 1);
    check("rstmid_cnt_before", 32'(sample_cnt), 2);
    check("rstmid_udr_before", 32'(underrun), 1);
    rst = 1'b1;
    #2;
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_trigs", {30'd0, trig_dac, trig_config}, 0);
    check("rstmid_sample_cnt", 32'(sample_cnt), 0);
    check("rstmid_flags", {28'd0, underrun, overrun, timeout, run_done}, 0);
    run = 1'b0;
    step(2);
    rst = 1'b0;
    step(2);

    // Unanswered DAC frame: watchdog abort or an indefinite wait.
    period = 16'd12; wav_empty = 1'b0;
    base = dac_cnt;
    run = 1'b1;
    k = 0;
    while (dac_cnt == base && k < 100) begin step(1); k++; end
    run = 1'b0;
    check("wd_trig_seen", 32'(dac_cnt - base), 1);
    t_trig = dac_t[base];
`ifdef SPI_SCHED_TIMEOUT_EN
    k = 0;
    while (!timeout && k < 300) begin step(1); k++; end
    gap = cyc - t_trig;
    check($sformatf("wd_timeout_at_%0d", gap), 32'(timeout && gap >= 127 && gap <= 129), 1);
    check("wd_cnt_unchanged", 32'(sample_cnt), 0);
    step(1);
    check("wd_guard_busy", 32'(busy), 1);
    step(2);
    check("wd_idle_after_guard", 32'(busy), 0);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    check("wd_cleared", 32'(timeout), 0);
`else
    step(200);
    check("wd_no_timeout", 32'(timeout), 0);
    check("wd_still_waiting", 32'(busy), 1);
`endif
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(2);
    check("end_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
